// File: rtl/addsub_pkg.sv
// Shared types and helpers for the iterative adder-subtractor.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int unsigned chunk_count(input int unsigned width, input int unsigned chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple of full-adder cells; also exposes the carry into the MSB.
module chunk_adder #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             cout_o,
    output logic             cmsb_o
);

    logic [CHUNK:0] c;

    assign c[0] = cin_i;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i+1]   = (a_i[i] & b_i[i]) | (a_i[i] & c[i]) | (b_i[i] & c[i]);
    end

    assign cout_o = c[CHUNK];
    assign cmsb_o = c[CHUNK-1];

endmodule

// File: rtl/addsub_iter.sv
// Multi-cycle adder-subtractor: CHUNK bits per clock, LSB chunk first, valid/ready on both sides.
// Define ADDSUB_ITER_SAT_EN to saturate the result on signed overflow.
module addsub_iter
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cbout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    if (CHUNK == 0) begin : g_bad_chunk
        $error("addsub_iter: CHUNK must be >= 1");
    end else if ((WIDTH % CHUNK) != 0) begin : g_bad_div
        $error("addsub_iter: WIDTH must be a multiple of CHUNK");
    end

    localparam int unsigned N  = chunk_count(WIDTH, CHUNK);
    localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [KW-1:0]    k_q, k_d;
    logic             cbout_q, cbout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;

    int unsigned      base;
    logic [CHUNK-1:0] chunk_a, chunk_b, chunk_sum;
    logic             chunk_cout, chunk_cmsb;
    logic [WIDTH-1:0] raw_sum, final_sum;
    logic             last_chunk, raw_ovf;

    always_comb begin
        base    = 32'(k_q) * CHUNK;
        chunk_a = a_q[base +: CHUNK];
        chunk_b = b_q[base +: CHUNK];
    end

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .a_i    (chunk_a),
        .b_i    (chunk_b),
        .cin_i  (carry_q),
        .sum_o  (chunk_sum),
        .cout_o (chunk_cout),
        .cmsb_o (chunk_cmsb)
    );

    always_comb begin
        raw_sum                 = acc_q;
        raw_sum[base +: CHUNK]  = chunk_sum;
        last_chunk              = (k_q == KW'(N - 1));
        raw_ovf                 = chunk_cmsb ^ chunk_cout;
        final_sum               = raw_sum;
`ifdef ADDSUB_ITER_SAT_EN
        // Overflow only when both operands share a sign, so b's MSB gives the true sign.
        if (raw_ovf) begin
            final_sum = b_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        k_d     = k_q;
        cbout_d = cbout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        neg_d   = neg_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b ^ {WIDTH{en}};
                    carry_d = (en == OP_SUB);
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d   = raw_sum;
                carry_d = chunk_cout;
                k_d     = k_q + KW'(1);
                if (last_chunk) begin
                    k_d     = '0;
                    cbout_d = chunk_cout;
                    ovf_d   = raw_ovf;
                    sum_d   = final_sum;
                    zero_d  = (final_sum == '0);
                    neg_d   = final_sum[WIDTH-1];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
            cbout_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            k_q     <= k_d;
            cbout_q <= cbout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cbout     = cbout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign neg       = neg_q;

endmodule

// File: tb/tb_addsub_iter.sv
// Directed, table-driven bench for addsub_iter at WIDTH=16, CHUNK=4.
module tb_addsub_iter;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned CHUNK = 4;
    localparam int unsigned N     = WIDTH / CHUNK;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             en;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cbout;
    logic             ovf;
    logic             zero;
    logic             neg;

    int total;
    int bad;

    addsub_iter #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .en        (en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cbout     (cbout),
        .ovf       (ovf),
        .zero      (zero),
        .neg       (neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        en;
        logic [15:0] sum;
        logic        cbout;
        logic        ovf;
        logic        zero;
        logic        neg;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operation, check latency, leave the DUT in DONE.
    task automatic start_and_wait(input logic [15:0] va, input logic [15:0] vb, input logic ven);
        int lat;
        a        = va;
        b        = vb;
        en       = ven;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a        = 16'hDEAD;
        b        = 16'hBEEF;
        en       = ~ven;
        lat      = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 1) check("in_ready_low_run", {31'd0, in_ready}, 32'd0);
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        check("latency", lat, N);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("drain_out_valid", {31'd0, out_valid}, 32'd0);
        check("drain_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic check_result(input vec_t v);
        check("sum", {16'd0, sum}, {16'd0, v.sum});
        check("cbout", {31'd0, cbout}, {31'd0, v.cbout});
        check("ovf", {31'd0, ovf}, {31'd0, v.ovf});
        check("zero", {31'd0, zero}, {31'd0, v.zero});
        check("neg", {31'd0, neg}, {31'd0, v.neg});
    endtask

    vec_t vecs[8];
    vec_t v;
    logic [15:0] held;

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        en        = 1'b0;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1};
`ifdef ADDSUB_ITER_SAT_EN
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{16'h8000, 16'h8000, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1};
`else
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0};
`endif
        vecs[3] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1};

        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_sum", {16'd0, sum}, 32'd0);
        check("rst_flags", {28'd0, cbout, ovf, zero, neg}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            start_and_wait(vecs[i].a, vecs[i].b, vecs[i].en);
            check_result(vecs[i]);
            drain();
            // Result must persist in IDLE after the handshake.
            check("hold_after_drain", {16'd0, sum}, {16'd0, vecs[i].sum});
        end

        // Back-pressure: DONE held for 3 cycles with a competing request.
        start_and_wait(16'h1234, 16'h4321, 1'b0);
        held     = sum;
        a        = 16'h1111;
        b        = 16'h2222;
        en       = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_sum", {16'd0, sum}, {16'd0, held});
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release_idle", {30'd0, in_ready, out_valid}, 32'd2);
        check("bp_sum_kept", {16'd0, sum}, 32'h5555);
        start_and_wait(16'h1111, 16'h2222, 1'b0);
        v = '{16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0, 1'b0};
        check_result(v);
        drain();

        // Reset mid-RUN at chunk index 2.
        a        = 16'hFFFF;
        b        = 16'h0001;
        en       = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_sum", {16'd0, sum}, 32'd0);
        check("mid_rst_flags", {28'd0, cbout, ovf, zero, neg}, 32'd0);
        tick();
        check("mid_rst_stays_idle", {31'd0, out_valid}, 32'd0);
        start_and_wait(16'h0003, 16'h0004, 1'b0);
        v = '{16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0, 1'b0};
        check_result(v);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/addsub_iter.md
Name: addsub_iter

Overview:
- Parametrised, multi-cycle signed/unsigned adder-subtractor; successor to the team's fixed 4-bit ripple add/sub.
- Processes operands CHUNK bits per clock, LSB chunk first, using a CHUNK-wide ripple adder with a registered carry between chunks.
- Valid/ready handshake on input and output. Produces the result plus carry/borrow, signed overflow, zero and negative flags.
- Sits in datapaths where area matters more than single-cycle latency.

Parameters:
- WIDTH, 16, operand and result width in bits.
- CHUNK, 4, bits added per cycle. WIDTH % CHUNK must be 0 and CHUNK >= 1; any other value is an elaboration error.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operands and en are valid.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- en  input  1  0 = A+B, 1 = A-B (computed as A + ~B + 1).
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer takes the result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cbout  output  1  raw carry out of the MSB. For subtract, 1 = no borrow and 0 = borrow.
- ovf  output  1  two's-complement overflow.
- zero  output  1  sum == 0.
- neg  output  1  sum[WIDTH-1].

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE; in_ready=1; out_valid=0; sum=0; cbout=0; ovf=0; zero=0; neg=0; internal carry and chunk index are 0.
- FSM IDLE:
  - in_ready=1.
  - On in_valid at a rising edge: latch a, b XOR {WIDTH{en}} and en; load carry register with en; set chunk index k=0; go to RUN.
- FSM RUN:
  - in_ready=0.
  - Each edge adds chunk k of a and of the modified b with the carry register.
  - Writes sum chunk k, updates the carry, and increments k.
  - On the edge processing k = WIDTH/CHUNK-1: capture cbout = chunk carry out and ovf = (carry into MSB) XOR (carry out of MSB); go to DONE.
- FSM DONE:
  - out_valid=1; zero and neg reflect the final sum.
  - Outputs are held stable while out_ready=0.
  - On an edge with out_ready=1: go to IDLE with out_valid=0. sum and flags keep their values until the next operation overwrites them.
- Latency:
  - Operation accepted at edge t; out_valid is high after edge t+N, where N = WIDTH/CHUNK.
  - Throughput: one operation per N+2 cycles at minimum.
- Inputs are ignored outside IDLE; a, b and en may change freely after acceptance.
- CHUNK == WIDTH: one RUN cycle, N = 1.
- Wrap-around: sum is truncated modulo 2^WIDTH, and the carry is visible only on cbout.
- rst during RUN or DONE: next edge returns all state and outputs to reset values, and the in-flight operation is discarded. rst has priority over every other event.
- sum is undefined-free: partial chunks are internal only and are never presented while out_valid=0. Implementation may use a separate result register.

Optional Feature:
- Macro ADDSUB_ITER_SAT_EN.
- When defined: in DONE, if ovf=1, sum saturates to 0x7FF..F when the true result is positive, or 0x800..0 when negative. Sign is taken from the MSB of the modified-b operand. zero and neg reflect the saturated value; ovf and cbout still report raw values.
- When undefined: sum is always the wrapped result, and there is no saturation logic.

Decomposition:
- Shared package addsub_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - op constants OP_ADD=1'b0, OP_SUB=1'b1;
  - function for the chunk count.
- One sub-module, chunk_adder: combinational CHUNK-bit ripple of full-adder cells. It outputs the chunk sum, carry out, and carry into its MSB (used for ovf).

Test Plan (WIDTH=16, CHUNK=4):
- a=0x1234, b=0x4321, en=0 → after 4 RUN edges: sum=0x5555, cbout=0, ovf=0, zero=0, neg=0.
- a=0x0005, b=0x0007, en=1 → sum=0xFFFE, cbout=0 (borrow), ovf=0, neg=1.
- a=0x7FFF, b=0x0001, en=0 → sum=0x8000, ovf=1, cbout=0. With ADDSUB_ITER_SAT_EN: sum=0x7FFF, neg=0.
- a=0xFFFF, b=0x0001, en=0 → sum=0x0000, cbout=1, zero=1, ovf=0. Also a=0x8000, b=0x0001, en=1 → sum=0x7FFF, ovf=1, cbout=1.
- Hold out_ready=0 for 3 cycles in DONE → out_valid and sum stable, in_ready=0, new in_valid ignored. Raise out_ready → IDLE next edge, next op accepted.
- Assert rst for 1 cycle at RUN k=2 → next edge: in_ready=1, out_valid=0, all outputs 0. Then a=0x0003, b=0x0004, en=0 → sum=0x0007.
